// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the L1-to-L2 cache arbiter.
// Optional round-robin arbitration is enabled with CACHE_ARB_ROUND_ROBIN_EN.
package cache_arb_pkg;

    localparam int LINE_W_DFLT = 256;
    localparam int ADDR_W_DFLT = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_DONE = 3'd3,
        D_DONE = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    function automatic logic is_busy(input arb_state_t s);
        return (s == I_BUSY) || (s == D_BUSY);
    endfunction

endpackage

// File: rtl/cache_arbiter_grant.sv
// Combinational winner select between I-side and D-side requests.
// CACHE_ARB_ROUND_ROBIN_EN: alternate on conflict; otherwise D-side has fixed priority.
module cache_arbiter_grant
    import cache_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    input  grant_t last_grant_i,
`endif
    output logic   valid_o,
    output grant_t grant_o
);

    always_comb begin
        valid_o = i_req_i | d_req_i;
        grant_o = GRANT_D;
        if (i_req_i && d_req_i) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            grant_o = (last_grant_i == GRANT_I) ? GRANT_D : GRANT_I;
`else
            grant_o = GRANT_D;
`endif
        end else if (i_req_i) begin
            grant_o = GRANT_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Two-to-one arbiter from split L1 I/D caches onto the unified L2 port.
// CACHE_ARB_ROUND_ROBIN_EN adds a last-grant register for round-robin conflicts.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int LINE_W = LINE_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_q,  line_d;

    logic   grant_valid;
    grant_t grant;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    grant_t last_q, last_d;
`endif

    cache_arbiter_grant u_grant (
        .i_req_i      (i_read),
        .d_req_i      (d_read | d_write),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        .last_grant_i (last_q),
`endif
        .valid_o      (grant_valid),
        .grant_o      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GRANT_I;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        line_d  = line_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_d = grant;
`endif
                    if (grant == GRANT_D) begin
                        state_d = D_BUSY;
                        addr_d  = d_address;
                        // read+write together is illegal; the write wins
                        write_d = d_write;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = I_BUSY;
                        addr_d  = i_address;
                        write_d = 1'b0;
                    end
                end
            end
            I_BUSY: begin
                if (mem_resp) begin
                    line_d  = mem_rdata;
                    state_d = I_DONE;
                end
            end
            D_BUSY: begin
                if (mem_resp) begin
                    line_d  = mem_rdata;
                    state_d = D_DONE;
                end
            end
            I_DONE:  state_d = IDLE;
            D_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_read    = is_busy(state_q) && !write_q;
    assign mem_write   = is_busy(state_q) &&  write_q;
    assign i_resp      = (state_q == I_DONE);
    assign d_resp      = (state_q == D_DONE);
    assign i_rdata     = line_q;
    assign d_rdata     = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: transaction-level arbitration model,
// randomized L2 latency/data, decoupled L2 and L1-response monitors.
module tb_cache_arbiter;

    logic         clk;
    logic         rst_n;
    logic [31:0]  i_address;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_address;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    cache_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_address   (i_address),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_address   (d_address),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic [255:0] wdata;
    } op_t;

    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] wdata;
        logic         side;
    } mreq_t;

    typedef struct {
        logic         side;
        logic [255:0] rdata;
        int           cyc;
    } rsp_t;

    mreq_t exp_mem_q[$];
    rsp_t  exp_resp_q[$];

    op_t iop[2];
    op_t dop[2];
    int  n_i, n_d;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int next_start_cyc = 0;

    bit           model_last_d = 1'b0;
    bit           l2_en = 1'b1;
    bit           l2_busy = 1'b0;
    bit           l2_side = 1'b0;
    int           force_lat = -1;
    bit           force_rdata_en = 1'b0;
    logic [255:0] force_rdata = '0;
    int           perturb_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // L2 responder: checks each request against the expected order, then answers
    initial begin
        mreq_t cur;
        rsp_t  r;
        int    cnt;
        cnt = 0;
        cur = '{addr: '0, wr: 1'b0, wdata: '0, side: 1'b0};
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!l2_en) continue;
            if (!rst_n) begin
                mem_resp = 1'b0;
                l2_busy  = 1'b0;
                continue;
            end
            mem_resp = 1'b0;
            if (l2_busy) begin
                chk("mem_op_held", {mem_read, mem_write}, {!cur.wr, cur.wr});
                chk("mem_addr_held", mem_address, cur.addr);
                if (cur.wr) chk("mem_wdata_held", mem_wdata, cur.wdata);
            end else if (mem_read || mem_write) begin
                chk("mem_start_cycle", cyc, next_start_cyc);
                if (exp_mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected actual read=%0b write=%0b required no request", mem_read, mem_write);
                end else begin
                    cur = exp_mem_q.pop_front();
                    chk("mem_op", {mem_read, mem_write}, {!cur.wr, cur.wr});
                    chk("mem_addr", mem_address, cur.addr);
                    if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
                    l2_busy = 1'b1;
                    l2_side = cur.side;
                    cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
                end
            end
            if (l2_busy) begin
                if (cnt == 0) begin
                    mem_rdata = force_rdata_en ? force_rdata : rand_line();
                    mem_resp  = 1'b1;
                    r.side  = cur.side;
                    r.rdata = mem_rdata;
                    r.cyc   = cyc + 1;
                    exp_resp_q.push_back(r);
                    l2_busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // L1 response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && (i_resp || d_resp)) begin
                chk("resp_exclusive", {i_resp, d_resp} == 2'b11, 0);
                chk("resp_mem_idle", {mem_read, mem_write}, 0);
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual i_resp=%0b d_resp=%0b required none", i_resp, d_resp);
                end else begin
                    r = exp_resp_q.pop_front();
                    chk("resp_side", d_resp, r.side);
                    chk("resp_i_rdata", i_rdata, r.rdata);
                    chk("resp_d_rdata", d_rdata, r.rdata);
                    chk("resp_cycle", cyc, r.cyc);
                    next_start_cyc = cyc + 2;
                end
            end
        end
    end

    task automatic run_side_i();
        for (int k = 0; k < n_i; k++) begin
            int w;
            bit got;
            w = 0;
            got = 1'b0;
            i_address = iop[k].addr;
            i_read = 1'b1;
            while (!got && w < 300) begin
                @(negedge clk);
                w++;
                if (i_resp) got = 1'b1;
                else if (perturb_mode != 0 && l2_busy && l2_side == 1'b0) i_address = $urandom;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL i_resp_timeout actual none required i_resp within 300 cycles");
                i_read = 1'b0;
                return;
            end
        end
        i_read = 1'b0;
    endtask

    task automatic run_side_d();
        for (int k = 0; k < n_d; k++) begin
            int w;
            bit got;
            w = 0;
            got = 1'b0;
            d_address = dop[k].addr;
            d_read    = dop[k].rd;
            d_write   = dop[k].wr;
            d_wdata   = dop[k].wdata;
            while (!got && w < 300) begin
                @(negedge clk);
                w++;
                if (d_resp) begin
                    got = 1'b1;
                end else if (perturb_mode != 0 && l2_busy && l2_side == 1'b1) begin
                    d_address = (perturb_mode == 2) ? 32'h0000_3000 : $urandom;
                    d_wdata   = rand_line();
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL d_resp_timeout actual none required d_resp within 300 cycles");
                d_read  = 1'b0;
                d_write = 1'b0;
                return;
            end
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // Transaction-level model: each side holds a list of pending ops; at every
    // arbitration point the winner is picked from which lists are non-empty.
    task automatic run_scn();
        int    a, b;
        bit    wd;
        mreq_t m;
        a = 0;
        b = 0;
        while (a < n_i || b < n_d) begin
            if (a < n_i && b < n_d) wd = RR_EN ? !model_last_d : 1'b1;
            else                    wd = (b < n_d);
            if (wd) begin
                m.addr = dop[b].addr; m.wr = dop[b].wr; m.wdata = dop[b].wdata; m.side = 1'b1;
                b++;
            end else begin
                m.addr = iop[a].addr; m.wr = 1'b0; m.wdata = '0; m.side = 1'b0;
                a++;
            end
            exp_mem_q.push_back(m);
            model_last_d = wd;
        end
        @(negedge clk);
        next_start_cyc = cyc + 1;
        fork
            run_side_i();
            run_side_d();
        join
        repeat (3) @(negedge clk);
        chk("drain_mem_queue", exp_mem_q.size(), 0);
        chk("drain_resp_queue", exp_resp_q.size(), 0);
        exp_mem_q.delete();
        exp_resp_q.delete();
    endtask

    function automatic op_t mk_op(input logic [31:0] addr, input logic rd, input logic wr,
                                  input logic [255:0] wdata);
        op_t o;
        o.addr = addr; o.rd = rd; o.wr = wr; o.wdata = wdata;
        return o;
    endfunction

    initial begin
        logic [255:0] all_a;
        logic [255:0] all_5;
        int           w;
        int           kind;
        all_a = {8{32'hAAAA_AAAA}};
        all_5 = {8{32'h5555_5555}};
        rst_n = 1'b0;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {mem_read, mem_write, i_resp, d_resp, mem_address}, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_i_rdata", i_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // first conflict after reset, D re-requesting once
        n_i = 1; n_d = 2;
        iop[0] = mk_op(32'h0000_1100, 1'b1, 1'b0, '0);
        dop[0] = mk_op(32'h0000_2100, 1'b1, 1'b0, '0);
        dop[1] = mk_op(32'h0000_2200, 1'b1, 1'b0, '0);
        run_scn();

        // I-only read, L2 latency 5, all-A line
        n_i = 1; n_d = 0;
        iop[0] = mk_op(32'h0000_1000, 1'b1, 1'b0, '0);
        force_lat = 5; force_rdata_en = 1'b1; force_rdata = all_a;
        run_scn();

        // D writeback with address change while busy
        n_i = 0; n_d = 1;
        dop[0] = mk_op(32'h0000_2040, 1'b0, 1'b1, all_5);
        force_lat = 3; force_rdata_en = 1'b0; perturb_mode = 2;
        run_scn();
        perturb_mode = 0;

        // zero-latency L2 on each side, and the illegal read+write treated as write
        force_lat = 0;
        n_i = 1; n_d = 0;
        iop[0] = mk_op(32'h0000_5000, 1'b1, 1'b0, '0);
        run_scn();
        n_i = 0; n_d = 1;
        dop[0] = mk_op(32'h0000_5040, 1'b1, 1'b1, rand_line());
        run_scn();
        force_lat = -1;

        // reset in I_BUSY, then a stray mem_resp in IDLE
        l2_en = 1'b0;
        @(negedge clk);
        i_address = 32'h0000_4000;
        i_read = 1'b1;
        w = 0;
        while (!mem_read && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("rst_test_busy_reached", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {mem_read, mem_write, i_resp, d_resp, mem_address}, 0);
        chk("rst_mid_mem_wdata", mem_wdata, 0);
        chk("rst_mid_i_rdata", i_rdata, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rdata = rand_line();
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stray_resp_ignored", {i_resp, d_resp, mem_read, mem_write}, 0);
        end
        model_last_d = 1'b0;
        l2_en = 1'b1;

        // conflict again with a D writeback mixed in
        n_i = 1; n_d = 2;
        iop[0] = mk_op(32'h0000_6000, 1'b1, 1'b0, '0);
        dop[0] = mk_op(32'h0000_7000, 1'b0, 1'b1, rand_line());
        dop[1] = mk_op(32'h0000_7040, 1'b1, 1'b0, '0);
        run_scn();

        // randomized mix
        perturb_mode = 1;
        for (int s = 0; s < 40; s++) begin
            n_i = $urandom_range(0, 2);
            n_d = $urandom_range(0, 2);
            if (n_i == 0 && n_d == 0) n_d = 1;
            for (int k = 0; k < 2; k++) begin
                iop[k] = mk_op($urandom & 32'hFFFF_FFE0, 1'b1, 1'b0, '0);
                kind = $urandom_range(0, 2);
                dop[k] = mk_op($urandom & 32'hFFFF_FFE0, kind != 1, kind != 0, rand_line());
            end
            run_scn();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-to-one arbiter between the split L1 caches (instruction and data) and the unified L2. It sits on the L2's upstream `mem_*` port, acting as the single initiator on that port. Each L1 miss or writeback is registered, forwarded as one 256-bit line transaction, and answered with a one-cycle response pulse. I-side is read-only; D-side issues reads and writebacks.

## Interface
- `LINE_W`, 256: cache line width in bits.
- `ADDR_W`, 32: address width.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_read`  in  1  I-cache read request; held until `i_resp`.
- `i_rdata`  out  LINE_W  line returned to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_read`  in  1  D-cache read request; held until `d_resp`.
- `d_write`  in  1  D-cache writeback request; held until `d_resp`.
- `d_wdata`  in  LINE_W  writeback line.
- `d_rdata`  out  LINE_W  line returned to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `mem_address`  out  ADDR_W  address to L2.
- `mem_read`  out  1  read request to L2.
- `mem_write`  out  1  write request to L2.
- `mem_wdata`  out  LINE_W  write line to L2.
- `mem_rdata`  in  LINE_W  line from L2, valid with `mem_resp`.
- `mem_resp`  in  1  L2 completion, one-cycle pulse.

## Operation
- States: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
- IDLE: sample requests.
  - If only `i_read` is high, go to I_BUSY.
  - If only `d_read` or `d_write` is high, go to D_BUSY.
  - If both sides request, the winner is chosen per Configuration.
  - At grant, latch address, op (read/write) and `d_wdata` into request registers.
- `d_read` and `d_write` both high is illegal. Arbiter treats it as a write.
- I_BUSY / D_BUSY:
  - `mem_address` and `mem_wdata` are driven from the request registers.
  - `mem_read` or `mem_write` is held high continuously until `mem_resp`.
  - Inputs from either L1 are ignored.
  - On `mem_resp`: capture `mem_rdata` into the line buffer and go to the matching DONE state.
- I_DONE / D_DONE:
  - Assert the matching `*_resp` for exactly one cycle.
  - The matching `*_rdata` equals the line buffer.
  - `mem_read` and `mem_write` are low.
  - Next state is IDLE.
- A requester must drop its request the cycle after `*_resp`, unless it is issuing a new one. IDLE treats any request present as new.
- `i_rdata` and `d_rdata` are both always driven from the line buffer. Only the `*_resp` pulse qualifies them.
- The non-granted requester simply waits. There is no timeout.

## Timing
- Reset values: state IDLE; all request registers, line buffer and last-grant bit 0. Every output is 0.
- Asynchronous reset mid-transaction returns to IDLE immediately. `mem_read`/`mem_write` drop without waiting for `mem_resp`. A stray `mem_resp` arriving in IDLE is ignored.
- Request-to-memory latency: request seen in IDLE at cycle T gives `mem_read`/`mem_write` high at T+1.
- Response latency: `mem_resp` at cycle R gives `*_resp` at R+1. State is IDLE at R+2.
- Minimum request-to-response latency is L2 latency + 2 cycles.
- `mem_resp` in the same cycle that `mem_read` first rises is legal and is handled identically.
- All outputs are decoded from registered state and registers only. There are no combinational paths from L1 inputs or `mem_*` inputs to outputs.
- Back-to-back operation: a new grant is possible in the IDLE cycle at R+2. Throughput is therefore at most one transaction per (L2 latency + 3) cycles.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, grant the side not granted last.
  - The last-grant bit updates on every grant.
  - Reset value of the last-grant bit is I, so the first conflict goes to D.
- `CACHE_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: D-cache always wins a conflict.
  - No last-grant register exists.

## Structure
- Package `cache_arb_pkg` holds:
  - `arb_state_t` enum (five states).
  - `LINE_W` / `ADDR_W` defaults.
  - A `grant_t` enum {GRANT_I, GRANT_D}.
- Sub-module `cache_arbiter_grant`: combinational winner select from the request vector plus last-grant bit. The round-robin macro is confined to this sub-module and the last-grant register.
- Top holds the FSM, request registers and line buffer.

## Test plan
- I-only read: `i_read`, `i_address`=0x0000_1000; L2 responds after 5 cycles with 0xAA…AA -> `mem_read` at T+1, `i_resp` one cycle with `i_rdata`=0xAA…AA, `d_resp` stays 0.
- D writeback: `d_write`, `d_address`=0x0000_2040, `d_wdata`=0x55…55 -> `mem_write` high, `mem_wdata`=0x55…55 until `mem_resp`; `d_resp` follows one cycle later.
- Conflict: `i_read` and `d_read` rise in the same cycle, twice in succession -> fixed priority gives D then D; with round-robin, D then I.
- Input change while busy: during D_BUSY, change `d_address` to 0x0000_3000 -> `mem_address` holds latched 0x0000_2040.
- Reset mid-transaction: assert `rst_n`=0 while in I_BUSY -> all outputs 0 immediately; stray `mem_resp` after release produces no `*_resp`.
- Zero-latency L2: `mem_resp` in the first BUSY cycle -> `*_resp` the next cycle, IDLE one cycle after.
